// File: rtl/divider_arbiter_pkg.sv
// rtl/divider_arbiter_pkg.sv - shared types and defaults for the divider arbiter
package divider_arbiter_pkg;

  // Controller states; the 3-bit encoding is fixed so waveforms stay readable
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

  localparam int DEF_SIZE    = 10;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// rtl/divider_arbiter_rr_arbiter.sv - combinational round-robin pick starting after the pointer
module divider_arbiter_rr_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk ptr+1, ptr+2, ... (wrapping) and take the first active request
  always_comb begin
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// rtl/divider_arbiter.sv - shares one divider among requesters; DIV_TIMEOUT_EN adds a WAIT watchdog
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int SIZE           = DEF_SIZE,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*SIZE-1:0] numerator_in,
  input  logic [NUM_REQ*SIZE-1:0] denominator_in,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      result_valid,
  output logic [SIZE-1:0]         quotient_out,
  output logic [SIZE-1:0]         remainder_out,
  output logic                    div_by_zero,
  output logic                    timeout_err,
  output logic                    busy,
  output logic                    div_clear,
  output logic                    div_start,
  output logic [SIZE-1:0]         div_numerator,
  output logic [SIZE-1:0]         div_denominator,
  input  logic                    div_done,
  input  logic [SIZE-1:0]         div_quotient,
  input  logic [SIZE-1:0]         div_remainder
);

  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("divider_arbiter: parameter out of range");
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, ptr;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] arb_req, arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [SIZE-1:0]    num_arr [NUM_REQ];
  logic [SIZE-1:0]    den_arr [NUM_REQ];
  logic [SIZE-1:0]    num_sel, den_sel;
  logic [SIZE-1:0]    res_q, res_r;
  logic               res_dbz;
  logic               timeout_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign num_arr[i] = numerator_in[i*SIZE +: SIZE];
    assign den_arr[i] = denominator_in[i*SIZE +: SIZE];
  end

  assign num_sel  = num_arr[arb_idx];
  assign den_sel  = den_arr[arb_idx];
  assign owner_oh = NUM_REQ'(1) << owner;
  assign busy     = (state != IDLE);

  // A requester whose result is being returned this cycle counts as released,
  // and nothing is granted while reset is held.
  assign arb_req = reset_n ? (req & ~result_valid) : '0;

  divider_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode plus the per-state strobes to requesters and divider
  always_comb begin
    state_nxt = state;
    grant     = '0;
    div_clear = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          grant     = arb_grant;
          state_nxt = (den_sel == '0) ? RESULT : CLEAR;
        end
      end
      CLEAR: begin
        div_clear = 1'b1;
        state_nxt = START;
      end
      START: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          state_nxt = RESULT;
        end else if (timeout_hit) begin
          div_clear = 1'b1;
          state_nxt = RESULT;
        end
      end
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner and its operands in IDLE, and the divider result in WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner           <= '0;
      ptr             <= PTR_RST;
      div_numerator   <= '0;
      div_denominator <= '0;
      res_q           <= '0;
      res_r           <= '0;
      res_dbz         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            owner           <= arb_idx;
            ptr             <= arb_idx;
            div_numerator   <= num_sel;
            div_denominator <= den_sel;
            if (den_sel == '0) begin
              res_q   <= '1;
              res_r   <= num_sel;
              res_dbz <= 1'b1;
            end else begin
              res_dbz <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (div_done) begin
            res_q <= div_quotient;
            res_r <= div_remainder;
          end else if (timeout_hit) begin
            res_q <= '0;
            res_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Present the staged result to the owner for one cycle; data holds afterwards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_valid  <= '0;
      quotient_out  <= '0;
      remainder_out <= '0;
      div_by_zero   <= 1'b0;
    end else if (state == RESULT) begin
      result_valid  <= owner_oh;
      quotient_out  <= res_q;
      remainder_out <= res_r;
      div_by_zero   <= res_dbz;
    end else begin
      result_valid  <= '0;
      div_by_zero   <= 1'b0;
    end
  end

`ifdef DIV_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             res_tmo;

  assign timeout_hit = (state == WAIT) && !div_done && (wait_cnt == CNT_LAST);

  // Count cycles spent in WAIT; restarts from zero on every operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                    wait_cnt <= '0;
  end

  // Remember a watchdog abort and report it alongside result_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_tmo     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && arb_valid) res_tmo <= 1'b0;
      else if (timeout_hit)           res_tmo <= 1'b1;
      timeout_err <= (state == RESULT) ? res_tmo : 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one integer_divider instance (repeated-subtraction, start/done, sticky done) between NUM_REQ requesters in the calculator datapath.
- Arbitrates requests round-robin, latches the winner's operands, clears and starts the divider, waits for done, and returns quotient/remainder to the winner.
- Short-circuits divide-by-zero, which would otherwise hang the divider.

Parameters:
- SIZE, 10, operand/result width; matches the divider's SIZE.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1023, watchdog limit in WAIT; used only with DIV_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until its result_valid bit.
- numerator_in  in  NUM_REQ*SIZE  flattened numerators; requester i at [i*SIZE +: SIZE].
- denominator_in  in  NUM_REQ*SIZE  flattened denominators, same packing.
- grant  out  NUM_REQ  one-hot; one-cycle pulse when a request is accepted.
- result_valid  out  NUM_REQ  one-hot; one-cycle pulse to the owner when results are valid.
- quotient_out  out  SIZE  registered quotient; valid while result_valid is high, held afterwards.
- remainder_out  out  SIZE  registered remainder; same timing.
- div_by_zero  out  1  high with result_valid when the denominator was 0.
- timeout_err  out  1  high with result_valid on watchdog abort; tied 0 without the macro.
- busy  out  1  high in any state other than IDLE.
- div_clear  out  1  active-high reset to the divider.
- div_start  out  1  divider start strobe.
- div_numerator  out  SIZE  latched numerator to the divider.
- div_denominator  out  SIZE  latched denominator to the divider.
- div_done  in  1  divider done (sticky).
- div_quotient  in  SIZE  divider quotient.
- div_remainder  in  SIZE  divider remainder.

Behaviour:
- Reset: all outputs 0; owner 0; rr pointer = NUM_REQ-1, so requester 0 has first priority. Reset mid-operation aborts immediately with no result_valid; the divider is cleared again on the next operation.
- FSM states: IDLE, CLEAR, START, WAIT, RESULT.
- IDLE, no req: stay in IDLE.
- IDLE, some req set:
  - Pick the first set bit searching from pointer+1, modulo NUM_REQ.
  - Pulse grant, record owner, latch operands into div_numerator/div_denominator.
  - Update pointer = owner.
  - If the latched denominator == 0, go to RESULT with quotient_out = all-ones, remainder_out = numerator, div_by_zero = 1.
  - Otherwise go to CLEAR.
- CLEAR: div_clear = 1 for exactly 1 cycle, which clears the divider's sticky done and q. Go to START.
- START: div_start = 1 for exactly 1 cycle. Go to WAIT.
- WAIT: when div_done = 1, register div_quotient/div_remainder and go to RESULT.
- RESULT: result_valid[owner] = 1 for 1 cycle, plus any error flags. Go to IDLE.
- Latency for quotient Q: result_valid is high Q+5 cycles after the IDLE grant cycle; e.g. 100/7 gives result at grant+19.
- Throughput: one operation in flight; a new grant can occur in the cycle after RESULT.
- Operands and req are sampled only in IDLE. Changes afterwards are ignored.
- Deasserting req mid-operation does not cancel the operation; the result is still delivered.
- Simultaneous requests are resolved by round-robin. A requester holding req continuously is served again only after every other active requester has been served once.
- Flags div_by_zero and timeout_err are cleared on leaving RESULT.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without div_done, go to RESULT with quotient_out = 0, remainder_out = 0, timeout_err = 1.
  - Pulse div_clear in that transition cycle.
- Undefined: no counter; WAIT waits indefinitely; timeout_err is tied 0.

Decomposition:
- Package divider_arbiter_pkg:
  - FSM state enum (IDLE, CLEAR, START, WAIT, RESULT), 3-bit encoding.
  - Default SIZE and NUM_REQ constants.
- One natural sub-module, rr_arbiter: req vector + pointer -> one-hot grant + index; combinational, parameterised by NUM_REQ.
- The divider stays external to this block.

Test Plan:
- Single request: req[0], 100/7 -> grant[0] at cycle 0; result_valid[0] at cycle 19 with quotient 14, remainder 2, div_by_zero 0.
- Divide by zero: req[2], 55/0 -> result_valid[2] 2 cycles after grant, quotient 0x3FF, remainder 55, div_by_zero 1; div_start never asserted.
- Contention: req = 4'b1111 held, all 9/3 -> grant order 0,1,2,3,0; each result quotient 3, remainder 0.
- Round-robin fairness: req[1] held continuously, req[3] asserted during req[1]'s operation -> next grant goes to 3, then 1.
- Reset mid-WAIT: reset_n low during 1000/1 -> all outputs 0 and no result_valid; next request 8/3 -> quotient 2, remainder 1.
- DIV_TIMEOUT_EN with TIMEOUT_CYCLES = 16, divider model that never raises done -> timeout_err 1 and quotient 0 with result_valid; div_clear pulsed.
